// File: rtl/cpe_arith_pkg.sv
// Shared arithmetic types and constants for the CPE compute datapath, plus the
// Booth/CSA sizing helpers used by int_multiplier_32.
package cpe_arith_pkg;

   localparam int DATA_W = 32;

   typedef logic signed [31:0] word_t;
   typedef logic signed [63:0] dword_t;

   // 34-bit sign-extended multiplier gives 17 radix-4 digits; the top digit is always zero
   localparam int BOOTH_DIGITS = 17;
   localparam int PP_W         = 33;
   localparam int CSA_OPERANDS = BOOTH_DIGITS + 2;
   localparam int CSA_LEVELS   = 6;
   localparam int CSA_MAX_GRP  = CSA_OPERANDS / 3;

   // Number of operands still to be summed at a given level of the 3:2 tree.
   function automatic int csa_count(input int level);
      int n;
      n = CSA_OPERANDS;
      for (int l = 0; l < level; l++) begin
         n = 2 * (n / 3) + (n % 3);
      end
      return n;
   endfunction

   // Each row carries its sign bit inverted, worth +2^(32+2k) too much; this constant takes it back.
   function automatic logic [63:0] sign_ext_const();
      logic [63:0] c;
      c = '0;
      for (int k = 0; k < BOOTH_DIGITS; k++) begin
         c = c - (64'd1 << (PP_W - 1 + 2 * k));
      end
      return c;
   endfunction

   localparam logic [63:0] SIGN_CONST = sign_ext_const();

endpackage

// File: rtl/int_multiplier_32_booth_pp_gen.sv
// One radix-4 Booth digit: encodes a multiplier bit triplet and selects the
// matching multiple of the multiplicand as an inverted-sign partial-product row.
module booth_pp_gen
   import cpe_arith_pkg::*;
(
   input  word_t            mcand_i,
   input  logic [2:0]       triplet_i,
   output logic [PP_W-1:0]  pp_o,
   output logic             neg_o
);

   logic            one;
   logic            two;
   logic            neg;
   logic [PP_W-1:0] mag;
   logic [PP_W-1:0] sel;

   always_comb begin
      one = triplet_i[1] ^ triplet_i[0];
      two = (triplet_i[2] & ~triplet_i[1] & ~triplet_i[0]) |
            (~triplet_i[2] & triplet_i[1] & triplet_i[0]);
      neg = triplet_i[2] & ~(triplet_i[1] & triplet_i[0]);

      mag = '0;
      if (one) begin
         mag = {mcand_i[31], mcand_i};
      end else if (two) begin
         mag = {mcand_i, 1'b0};
      end

      // Negation is one's complement here; the +1 is injected by the caller at the row's LSB
      sel   = neg ? ~mag : mag;
      pp_o  = {~sel[PP_W-1], sel[PP_W-2:0]};
      neg_o = neg;
   end

endmodule

// File: rtl/int_multiplier_32.sv
// Signed 32x32 multiplier (low 32 product bits), one-cycle registered, throughput 1.
// Define INT_MULT_OVF_EN to add the registered overflow output.
module int_multiplier_32
   import cpe_arith_pkg::*;
#(
   parameter int DATA_W = cpe_arith_pkg::DATA_W
)(
   input  logic   clk,
   input  logic   reset,
   input  logic   start,
   input  word_t  multiplier,
   input  word_t  multiplicand,
   output word_t  product,
   output logic   ready
`ifdef INT_MULT_OVF_EN
   ,
   output logic   overflow
`endif
);

   if (DATA_W != 32) begin : g_bad_width
      $error("int_multiplier_32 supports DATA_W == 32 only");
   end

   logic [34:0]     y_ext;
   logic [PP_W-1:0] pp   [BOOTH_DIGITS];
   logic            neg  [BOOTH_DIGITS];
   logic [63:0]     neg_vec;
   logic [63:0]     tree [CSA_LEVELS+1][CSA_OPERANDS];
   logic [63:0]     full;

   word_t product_q, product_d;
   logic  ready_q, ready_d;

   assign y_ext = {multiplier[31], multiplier[31], multiplier, 1'b0};

   for (genvar k = 0; k < BOOTH_DIGITS; k++) begin : g_pp
      booth_pp_gen u_pp (
         .mcand_i   (multiplicand),
         .triplet_i (y_ext[2*k+2 -: 3]),
         .pp_o      (pp[k]),
         .neg_o     (neg[k])
      );
   end

   always_comb begin
      neg_vec = '0;
      for (int k = 0; k < BOOTH_DIGITS; k++) begin
         neg_vec[2*k] = neg[k];
      end
   end

   // Carry-save reduction: 19 operands -> 2, then one carry-propagate add
   always_comb begin
      logic [63:0] a, b, c;
      int          cnt;
      int          grp;
      a   = '0;
      b   = '0;
      c   = '0;
      cnt = 0;
      grp = 0;
      for (int l = 0; l <= CSA_LEVELS; l++) begin
         for (int k = 0; k < CSA_OPERANDS; k++) begin
            tree[l][k] = '0;
         end
      end

      for (int k = 0; k < BOOTH_DIGITS; k++) begin
         tree[0][k] = {31'b0, pp[k]} << (2 * k);
      end
      tree[0][BOOTH_DIGITS]   = neg_vec;
      tree[0][BOOTH_DIGITS+1] = SIGN_CONST;

      for (int l = 0; l < CSA_LEVELS; l++) begin
         cnt = csa_count(l);
         grp = cnt / 3;
         for (int g = 0; g < CSA_MAX_GRP; g++) begin
            if (g < grp) begin
               a = tree[l][3*g];
               b = tree[l][3*g+1];
               c = tree[l][3*g+2];
               tree[l+1][2*g]   = a ^ b ^ c;
               tree[l+1][2*g+1] = ((a & b) | (a & c) | (b & c)) << 1;
            end
         end
         for (int r = 0; r < 2; r++) begin
            if (3 * grp + r < cnt) begin
               tree[l+1][2*grp+r] = tree[l][3*grp+r];
            end
         end
      end

      full = tree[CSA_LEVELS][0] + tree[CSA_LEVELS][1];
   end

`ifdef INT_MULT_OVF_EN
   logic ovf_q, ovf_d;
   logic ovf_full;

   assign ovf_full = ~((&full[63:31]) | ~(|full[63:31]));
   assign overflow = ovf_q;
`else
   logic unused_hi;
   assign unused_hi = ^full[63:32];
`endif

   always_comb begin
      product_d = product_q;
      ready_d   = start;
      if (start) begin
         product_d = full[31:0];
      end
   end

`ifdef INT_MULT_OVF_EN
   always_comb begin
      ovf_d = ovf_q;
      if (start) begin
         ovf_d = ovf_full;
      end
   end
`endif

   // Output register stage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         product_q <= '0;
         ready_q   <= 1'b0;
`ifdef INT_MULT_OVF_EN
         ovf_q     <= 1'b0;
`endif
      end else begin
         product_q <= product_d;
         ready_q   <= ready_d;
`ifdef INT_MULT_OVF_EN
         ovf_q     <= ovf_d;
`endif
      end
   end

   assign product = product_q;
   assign ready   = ready_q;

endmodule

// File: tb/tb_int_multiplier_32.sv
// Scoreboard bench for int_multiplier_32: driver pushes expected products, a
// negedge monitor pops and compares whenever ready is high.
module tb_int_multiplier_32;
   import cpe_arith_pkg::*;

   logic  clk = 1'b0;
   logic  reset;
   logic  start;
   word_t multiplier;
   word_t multiplicand;
   word_t product;
   logic  ready;
`ifdef INT_MULT_OVF_EN
   logic  overflow;
`endif

   typedef struct {
      word_t prod;
      logic  ovf;
   } exp_t;

   exp_t  sb[$];
   int    vectors     = 0;
   int    miscompares = 0;
   word_t held        = '0;

   localparam word_t MIN_W = 32'sh8000_0000;
   localparam word_t MAX_W = 32'sh7FFF_FFFF;

   always #5 clk = ~clk;

   int_multiplier_32 dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplier   (multiplier),
      .multiplicand (multiplicand),
      .product      (product),
      .ready        (ready)
`ifdef INT_MULT_OVF_EN
      ,
      .overflow     (overflow)
`endif
   );

   function automatic exp_t model(input word_t a, input word_t b);
      longint p;
      exp_t   e;
      p      = longint'(a) * longint'(b);
      e.prod = word_t'(p);
      e.ovf  = (p < -64'sd2147483648) || (p > 64'sd2147483647);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic issue(input word_t a, input word_t b);
      multiplier   = a;
      multiplicand = b;
      start        = 1'b1;
      sb.push_back(model(a, b));
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      start        = 1'b0;
      multiplier   = word_t'($urandom);
      multiplicand = word_t'($urandom);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: a result is due exactly when ready is high; otherwise product must hold
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         held = '0;
      end else if (ready) begin
         if (sb.size() == 0) begin
            check("ready_without_start", {31'b0, ready}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("product", product, e.prod);
`ifdef INT_MULT_OVF_EN
            check("overflow", {31'b0, overflow}, {31'b0, e.ovf});
`endif
            held = e.prod;
         end
      end else begin
         check("product_hold", product, held);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      word_t a, b;
      int unsigned u;

      reset        = 1'b0;
      start        = 1'b0;
      multiplier   = '0;
      multiplicand = '0;
      #1;
      check("reset_product", product, 32'd0);
      check("reset_ready", {31'b0, ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // Idle after reset: ready stays low, product stays zero
      for (int i = 0; i < 4; i++) begin
         idle(1);
         check("idle_ready", {31'b0, ready}, 32'd0);
         check("idle_product", product, 32'd0);
      end

      issue(32'sd0, 32'sd0);
      idle(1);
      issue(-32'sd123456, 32'sd789);
      idle(2);

      for (int i = 0; i < 100; i++) begin
         u = $urandom_range(32'h7FFF_FFFF, 0);
         a = -word_t'(u);
         b = word_t'($urandom_range(32'h1FFF_FFFF, 0));
         issue(a, b);
      end
      idle(2);

      issue(MIN_W, -32'sd1);
      issue(-32'sd1, MIN_W);
      issue(MIN_W, MIN_W);
      issue(32'sd7, -32'sd6);
      issue(-32'sd6, 32'sd7);
      issue(MAX_W, MAX_W);
      issue(-32'sd1, -32'sd1);
      issue(32'sd0, MIN_W);
      issue(-32'sd5, 32'sd0);
      issue(32'sd65536, 32'sd65536);
      idle(3);

      // Full-range random pairs, each followed by its commuted twin, with idle gaps
      for (int i = 0; i < 60; i++) begin
         a = word_t'($urandom);
         b = word_t'($urandom);
         issue(a, b);
         issue(b, a);
         if ($urandom_range(3, 0) == 0) idle($urandom_range(2, 1));
      end
      idle(2);

      // Reset mid-stream: the edge just taken is flushed, nothing else emerges
      issue(32'sd1234, 32'sd5678);
      issue(32'sd4321, -32'sd8765);
      reset = 1'b0;
      #1;
      check("midreset_product", product, 32'd0);
      check("midreset_ready", {31'b0, ready}, 32'd0);
`ifdef INT_MULT_OVF_EN
      check("midreset_overflow", {31'b0, overflow}, 32'd0);
`endif
      sb.delete();
      @(posedge clk);
      #1;
      check("inreset_product", product, 32'd0);
      check("inreset_ready", {31'b0, ready}, 32'd0);
      start = 1'b0;
      reset = 1'b1;
      idle(1);
      check("postreset_ready", {31'b0, ready}, 32'd0);
      issue(-32'sd300, 32'sd41);
      issue(MIN_W, 32'sd2);
      idle(3);

      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
